// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage between the PC register and
// instruction memory.
//
// Each cycle it tries to accept the current PC. It issues in-order requests
// to instruction memory. Each returned word is queued with its PC for the
// decoder. A taken jump or branch (flush_i) empties the queue and marks
// every in-flight request so that its response is discarded.
//
// Ports:
//   clk_i, reset_ni      clock, asynchronous active-low reset
//   pc_i                 current PC from the PC register
//   flush_i              jump / taken branch this cycle
//   halt_o               pc_i not accepted this cycle (stall the PC register)
//   imem_req_o/addr_o    memory request valid / address (= pc_i)
//   imem_gnt_i           memory accepts the request
//   imem_rvalid_i/rdata_i in-order memory response
//   inst_valid_o/inst_o/inst_pc_o  queue head for the decoder
//   dec_ready_i          decoder consumes the head when inst_valid_o is high
module ifetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        halt_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        dec_ready_i
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_cnt;

  logic [PW-1:0] tag_wr, tag_rd;
  logic [PW-1:0] q_wr, q_rd;

  logic [31:0] tag_mem [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_inst  [DEPTH];

  logic          pop;
  logic          credit;
  logic          acc;
  logic          rsp;
  logic          push;
  logic [CW:0]   used;
  logic [31:0]   tag_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop          = inst_valid_o & dec_ready_i;
    used         = {1'b0, out_cnt} + {1'b0, q_cnt} - (CW + 1)'(pop);
    credit       = used < (CW + 1)'(DEPTH);
    // Gating with reset_ni keeps the request low and halt high while reset
    // is held, even though the cleared counters would otherwise give credit.
    imem_req_o   = reset_ni & credit & ~flush_i;
    acc          = imem_req_o & imem_gnt_i;
    halt_o       = ~acc;
    imem_addr_o  = pc_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp          = imem_rvalid_i & (out_cnt != '0);
    push         = rsp & (drop_cnt == '0) & ~flush_i;
    tag_head     = tag_mem[tag_rd];
    inst_valid_o = (q_cnt != '0);
    inst_o       = q_inst[q_rd];
    inst_pc_o    = q_pc[q_rd];
  end

  // In-flight tracking: PC tags, outstanding and to-be-dropped counters.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      if (acc) begin
        tag_mem[tag_wr] <= pc_i;
        tag_wr          <= ptr_inc(tag_wr);
      end
      if (rsp) begin
        tag_rd <= ptr_inc(tag_rd);
      end

      case ({acc, rsp})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase

      // No request is accepted in a flush cycle, so everything still
      // outstanding after this cycle's response belongs to the wrong path.
      if (flush_i) begin
        drop_cnt <= out_cnt - CW'(rsp);
      end else if (rsp && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Instruction queue of {pc, inst} pairs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q_cnt <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (flush_i) begin
      q_cnt <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
    end else begin
      if (push) begin
        q_pc[q_wr]   <= tag_head;
        q_inst[q_wr] <= imem_rdata_i;
        q_wr         <= ptr_inc(q_wr);
      end
      if (pop) begin
        q_rd <= ptr_inc(q_rd);
      end
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit (DEPTH = 2). The bench plays the PC
// register (advance by 4 unless halted, load target on flush) and an
// in-order fixed-latency memory whose data word is address ^ 0xDEAD0000.
module tb_ifetch_unit;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        halt_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        dec_ready_i;

  always #5 clk_i = ~clk_i;

  ifetch_unit #(.DEPTH(2)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .halt_o       (halt_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .dec_ready_i  (dec_ready_i)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc;
  int          lat;
  int          n_halt;
  logic [31:0] pc_r;
  logic [31:0] flush_tgt;
  int          mq_due[$];
  logic [31:0] mq_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_q[$];
  logic        s_halt, s_req, s_valid;
  logic [31:0] s_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] exp[$]);
    chk({tag, "_count"}, 32'(got_pc.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_pc.size(); i++) begin
      chk({tag, "_pc"}, got_pc[i], exp[i]);
      chk({tag, "_inst"}, got_inst[i], exp[i] ^ K);
    end
  endtask

  task automatic drive_mem();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mq_addr[0] ^ K;
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end
    pc_i = pc_r;
  endtask

  // One cycle: sample settled outputs, update PC/memory models, cross the
  // clock edge and drive the next cycle's inputs.
  task automatic tick();
    #1;
    s_halt  = halt_o;
    s_req   = imem_req_o;
    s_valid = inst_valid_o;
    s_pc    = inst_pc_o;
    if (halt_o) n_halt++;
    if (inst_valid_o && dec_ready_i) begin
      got_pc.push_back(inst_pc_o);
      got_inst.push_back(inst_o);
    end
    if (imem_req_o && imem_gnt_i) begin
      acc_log.push_back(imem_addr_o);
      mq_due.push_back(cyc + lat);
      mq_addr.push_back(imem_addr_o);
    end
    if (flush_i) pc_r = flush_tgt;
    else if (!halt_o) pc_r = pc_r + 32'd4;
    @(posedge clk_i);
    #1;
    cyc++;
    flush_i = 1'b0;
    drive_mem();
  endtask

  task automatic do_reset();
    reset_ni      = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b1;
    dec_ready_i   = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    mq_due.delete();
    mq_addr.delete();
    got_pc.delete();
    got_inst.delete();
    acc_log.delete();
    pc_r = 32'h120;
    pc_i = pc_r;
    lat  = 1;
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_halt", 32'(halt_o), 32'd1);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    cyc      = 0;
    n_halt   = 0;
    drive_mem();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b1;
    #1;

    // Streaming, 1-cycle memory, decoder always ready.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin
        chk("s_req0", 32'(s_req), 32'd1);
        chk("s_halt0", 32'(s_halt), 32'd0);
        chk("s_valid0", 32'(s_valid), 32'd0);
      end
      if (c == 1) chk("s_valid1", 32'(s_valid), 32'd0);
      if (c == 2) begin
        chk("s_valid2", 32'(s_valid), 32'd1);
        chk("s_pc2", s_pc, 32'h120);
      end
    end
    chk("s_halts", 32'(n_halt), 32'd0);
    exp_q = '{32'h120, 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134};
    chk_seq("stream", exp_q);

    // Decoder backpressure from cycle 3 to 6, then release.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      dec_ready_i = (c < 3 || c >= 7);
      tick();
      if (c == 3) chk("bp_req3", 32'(s_req), 32'd0);
      if (c == 5) begin
        chk("bp_req5", 32'(s_req), 32'd0);
        chk("bp_halt5", 32'(s_halt), 32'd1);
        chk("bp_valid5", 32'(s_valid), 32'd1);
        chk("bp_pc5", s_pc, 32'h124);
      end
      if (c == 6) chk("bp_pc_frozen", pc_r, 32'h12C);
      if (c == 7) chk("full_pop_req", 32'(s_req), 32'd1);
      if (c == 8) chk("full_pop_head", s_pc, 32'h128);
    end
    exp_q = '{32'h120, 32'h124, 32'h128, 32'h12C, 32'h130};
    chk_seq("bp", exp_q);

    // Grant stall for 3 cycles at PC 0x124.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      imem_gnt_i = !(c >= 1 && c <= 3);
      tick();
      if (c == 1) begin
        chk("gs_req1", 32'(s_req), 32'd1);
        chk("gs_halt1", 32'(s_halt), 32'd1);
      end
      if (c == 3) chk("gs_pc_held", pc_r, 32'h124);
      if (c == 4) chk("gs_halt4", 32'(s_halt), 32'd0);
    end
    chk("gs_halts", 32'(n_halt), 32'd3);
    begin
      int n124 = 0;
      foreach (acc_log[i]) if (acc_log[i] == 32'h124) n124++;
      chk("gs_issue_once", 32'(n124), 32'd1);
    end
    exp_q = '{32'h120, 32'h124, 32'h128};
    chk_seq("gs", exp_q);

    // Flush with 0x124 queued and one request in flight, 2-cycle memory.
    do_reset();
    lat = 2;
    for (int c = 0; c < 10; c++) begin
      dec_ready_i = (c != 4);
      if (c == 4) begin
        flush_i   = 1'b1;
        flush_tgt = 32'h200;
      end
      tick();
      if (c == 4) begin
        chk("fl_req4", 32'(s_req), 32'd0);
        chk("fl_valid4", 32'(s_valid), 32'd1);
      end
      if (c == 5) chk("fl_valid5", 32'(s_valid), 32'd0);
      if (c == 7) chk("fl_valid7", 32'(s_valid), 32'd0);
      if (c == 8) begin
        chk("fl_valid8", 32'(s_valid), 32'd1);
        chk("fl_pc8", s_pc, 32'h200);
      end
    end
    chk("fl_first_req", acc_log[3], 32'h200);
    exp_q = '{32'h120, 32'h200, 32'h204};
    chk_seq("fl", exp_q);

    // Flush with 2 requests outstanding and a response in the flush cycle.
    do_reset();
    lat = 2;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        flush_i   = 1'b1;
        flush_tgt = 32'h300;
      end
      tick();
      if (c == 2) chk("fl2_req2", 32'(s_req), 32'd0);
    end
    chk("fl2_first_req", acc_log[2], 32'h300);
    exp_q = '{32'h300, 32'h304};
    chk_seq("fl2", exp_q);

    // Asynchronous reset mid-cycle with queue and requests nonempty.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      dec_ready_i = 1'b0;
      tick();
      if (c == 2) begin
        chk("mr_valid_pre", 32'(s_valid), 32'd1);
        chk("mr_req_pre", 32'(s_req), 32'd0);
      end
    end
    #2;
    reset_ni = 1'b0;
    #1;
    chk("mr_valid_async", 32'(inst_valid_o), 32'd0);
    chk("mr_halt_async", 32'(halt_o), 32'd1);
    chk("mr_req_async", 32'(imem_req_o), 32'd0);
    do_reset();
    // Spurious response with nothing outstanding must be ignored.
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0BAD_0BAD;
    for (int c = 0; c < 4; c++) begin
      tick();
    end
    chk("mr_first_req", acc_log[0], 32'h120);
    exp_q = '{32'h120, 32'h124};
    chk_seq("mr", exp_q);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
